// File: rtl/reduction_table_writer_if.sv
// Bus bundle between a table-generation requester and reduction_table_writer.
// The err signal and its modport entries exist only when REDC_TABLE_RANGE_CHECK_EN is defined.
interface reduction_table_writer_if;
    logic        start;
    logic [29:0] modulus;
    logic        bank_sel;
    logic        busy;
    logic        done;
`ifdef REDC_TABLE_RANGE_CHECK_EN
    logic        err;
`endif
    logic        tbl_we;
    logic        tbl_bank;
    logic [5:0]  tbl_addr;
    logic [29:0] tbl_data;

`ifdef REDC_TABLE_RANGE_CHECK_EN
    modport master (
        output start, modulus, bank_sel,
        input  busy, done, err, tbl_we, tbl_bank, tbl_addr, tbl_data
    );
    modport slave (
        input  start, modulus, bank_sel,
        output busy, done, err, tbl_we, tbl_bank, tbl_addr, tbl_data
    );
`else
    modport master (
        output start, modulus, bank_sel,
        input  busy, done, tbl_we, tbl_bank, tbl_addr, tbl_data
    );
    modport slave (
        input  start, modulus, bank_sel,
        output busy, done, tbl_we, tbl_bank, tbl_addr, tbl_data
    );
`endif
endinterface

// File: rtl/reduction_table_writer.sv
// Runtime generator for the 64-entry window-reduction table T[k] = (k * 2^30) mod q.
// One entry is written per cycle into an external RAM; acc is stepped by r = 2^30 mod q
// with a single conditional subtract, so no multiplier or divider is needed.
// Optional macro REDC_TABLE_RANGE_CHECK_EN: rejects q unless odd and in (2^29, 2^30),
// adding an ERR state and the err pulse.
module reduction_table_writer (
    input logic                      i_clk,
    input logic                      i_rst,
    reduction_table_writer_if.slave  io_bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef REDC_TABLE_RANGE_CHECK_EN
    localparam logic [2:0] ST_ERR   = 3'd4;
`endif

    logic [2:0]  r_state;
    logic [29:0] r_q;
    logic [29:0] r_r;
    logic        r_bank;
    logic [5:0]  r_k;
    logic [29:0] r_acc;

    logic [2:0]  w_state_nxt;
    logic [29:0] w_q_nxt;
    logic [29:0] w_r_nxt;
    logic        w_bank_nxt;
    logic [5:0]  w_k_nxt;
    logic [29:0] w_acc_nxt;

    logic [30:0] w_sum;
    logic [29:0] w_diff;
    logic [29:0] w_r_init;

    // acc + r never exceeds 2*q, so the 30-bit difference is exact whenever sum >= q
    assign w_sum    = {1'b0, r_acc} + {1'b0, r_r};
    assign w_diff   = w_sum[29:0] - r_q;
    // 2^30 - q taken modulo 2^30
    assign w_r_init = 30'd0 - r_q;

    // Next-state and datapath update for the generation sequence
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_r_nxt     = r_r;
        w_bank_nxt  = r_bank;
        w_k_nxt     = r_k;
        w_acc_nxt   = r_acc;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.start) begin
                    w_q_nxt     = io_bus.modulus;
                    w_bank_nxt  = io_bus.bank_sel;
                    w_state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                w_r_nxt     = w_r_init;
                w_k_nxt     = 6'd0;
                w_acc_nxt   = 30'd0;
                w_state_nxt = ST_WRITE;
`ifdef REDC_TABLE_RANGE_CHECK_EN
                if (!(r_q[29] && r_q[0])) begin
                    w_state_nxt = ST_ERR;
                end
`endif
            end
            ST_WRITE: begin
                w_acc_nxt = (w_sum >= {1'b0, r_q}) ? w_diff : w_sum[29:0];
                w_k_nxt   = r_k + 6'd1;
                if (r_k == 6'd63) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
`ifdef REDC_TABLE_RANGE_CHECK_EN
            ST_ERR: begin
                w_state_nxt = ST_IDLE;
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_q     <= 30'd0;
            r_r     <= 30'd0;
            r_bank  <= 1'b0;
            r_k     <= 6'd0;
            r_acc   <= 30'd0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_r     <= w_r_nxt;
            r_bank  <= w_bank_nxt;
            r_k     <= w_k_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    // Outputs decoded purely from registered state
    always_comb begin
        io_bus.busy     = (r_state != ST_IDLE);
        io_bus.done     = (r_state == ST_DONE);
        io_bus.tbl_we   = (r_state == ST_WRITE);
        io_bus.tbl_bank = r_bank;
        io_bus.tbl_addr = r_k;
        io_bus.tbl_data = r_acc;
    end

`ifdef REDC_TABLE_RANGE_CHECK_EN
    // Rejection pulse
    always_comb begin
        io_bus.err = (r_state == ST_ERR);
    end
`endif

endmodule

// File: tb/tb_reduction_table_writer.sv
// Self-checking bench for reduction_table_writer: vector table plus scoreboard of expected
// table writes, computed from (k * 2^30) mod q in 64-bit arithmetic.
module tb_reduction_table_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reduction_table_writer_if bus ();

    reduction_table_writer dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    typedef struct {
        logic [29:0] q;
        logic        bank;
        logic [29:0] t1;
        logic [29:0] t2;
        logic [29:0] t63;
    } vec_t;

    typedef struct {
        logic        bank;
        logic [5:0]  addr;
        logic [29:0] data;
    } wr_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int          n_wr  = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [29:0] cap [0:1][0:63];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [29:0] model_t(input logic [29:0] q, input int k);
        longint p;
        longint m;
        p = longint'(k) << 30;
        m = longint'({34'd0, q});
        return 30'(p % m);
    endfunction

    task automatic push_expected(input logic [29:0] q, input logic bank);
        wr_t e;
        for (int k = 0; k < 64; k++) begin
            e.bank = bank;
            e.addr = 6'(k);
            e.data = model_t(q, k);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard: every observed write is matched against the head of the expected queue
    always @(negedge clk) begin
        if (bus.tbl_we === 1'b1) begin
            n_wr++;
            cap[bus.tbl_bank][bus.tbl_addr] = bus.tbl_data;
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", longint'(bus.tbl_addr), -1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", longint'(bus.tbl_addr), longint'(mon_e.addr));
                chk("wr_data", longint'(bus.tbl_data), longint'(mon_e.data));
                chk("wr_bank", longint'(bus.tbl_bank), longint'(mon_e.bank));
            end
        end
    end

    // One generation run; poke_j re-asserts start mid-run, rst_j resets during cycle rst_j
    task automatic run_txn(input logic [29:0] q, input logic bank,
                           input int poke_j, input int rst_j);
        int   done_j;
        int   wr0;
        logic busy_ok;
        logic stray;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.modulus  = q;
        bus.bank_sel = bank;
        push_expected(q, bank);
        wr0 = n_wr;
        @(posedge clk);
        done_j  = 0;
        busy_ok = 1'b1;
        for (int j = 1; j <= 100 && done_j == 0; j++) begin
            @(negedge clk);
            if (j == 1) begin
                bus.start    = 1'b0;
                bus.modulus  = 30'($urandom);
                bus.bank_sel = ~bank;
            end
            if (j == poke_j) begin
                bus.start    = 1'b1;
                bus.modulus  = 30'd536870913;
                bus.bank_sel = 1'b1;
            end
            if (j == poke_j + 1) bus.start = 1'b0;
            if (rst_j != 0 && j == rst_j) rst = 1'b1;
            if (rst_j != 0 && j == rst_j + 1) begin
                chk("rst_tbl_we", longint'(bus.tbl_we), 0);
                chk("rst_busy", longint'(bus.busy), 0);
                chk("rst_done", longint'(bus.done), 0);
                rst = 1'b0;
                #1;
                chk("rst_pending", longint'(exp_q.size()), longint'(64 - (rst_j - 1)));
                exp_q.delete();
                stray = 1'b0;
                repeat (70) begin
                    @(negedge clk);
                    if (bus.done !== 1'b0 || bus.tbl_we !== 1'b0) stray = 1'b1;
                end
                chk("rst_no_done", longint'(stray), 0);
                return;
            end
            if (bus.done === 1'b1) done_j = j;
            else if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        chk("done_cycle", longint'(done_j), 66);
        chk("busy_window", longint'(busy_ok), 1);
        @(negedge clk);
        chk("busy_after", longint'(bus.busy), 0);
        chk("done_pulse", longint'(bus.done), 0);
        #1;
        chk("write_count", longint'(n_wr - wr0), 64);
        chk("queue_empty", longint'(exp_q.size()), 0);
        exp_q.delete();
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) stray = 1'b1;
        end
        chk("idle_quiet", longint'(stray), 0);
    endtask

`ifdef REDC_TABLE_RANGE_CHECK_EN
    task automatic run_err(input logic [29:0] q);
        int wr0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.modulus  = q;
        bus.bank_sel = 1'b0;
        wr0 = n_wr;
        @(posedge clk);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j == 1) bus.start = 1'b0;
            if (j == 2) chk("err_pulse", longint'(bus.err), 1);
            else chk("err_quiet", longint'(bus.err), 0);
            if (j == 3) chk("err_busy_low", longint'(bus.busy), 0);
        end
        chk("err_no_writes", longint'(n_wr - wr0), 0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [0:3];
        int   n_ge;
        vecs[0] = '{30'd1068564481, 1'b0, 30'd5177343,   30'd10354686,  30'd326172609};
        vecs[1] = '{30'd536870913,  1'b1, 30'd536870911, 30'd536870909, 30'd536870787};
        vecs[2] = '{30'd1073741823, 1'b0, 30'd1,         30'd2,         30'd63};
        vecs[3] = '{30'd805306369,  1'b1, 30'd268435455, 30'd536870910, 30'd805306285};

        bus.start    = 1'b0;
        bus.modulus  = 30'd0;
        bus.bank_sel = 1'b0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", longint'(bus.busy), 0);
        chk("reset_done", longint'(bus.done), 0);
        chk("reset_tbl_we", longint'(bus.tbl_we), 0);
        chk("reset_tbl_bank", longint'(bus.tbl_bank), 0);
        chk("reset_tbl_addr", longint'(bus.tbl_addr), 0);
        chk("reset_tbl_data", longint'(bus.tbl_data), 0);
`ifdef REDC_TABLE_RANGE_CHECK_EN
        chk("reset_err", longint'(bus.err), 0);
`endif
        // start held together with reset must be ignored
        bus.start   = 1'b1;
        bus.modulus = 30'd1068564481;
        @(negedge clk);
        chk("rst_wins_busy", longint'(bus.busy), 0);
        bus.start = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        chk("rst_wins_idle", longint'(bus.busy), 0);

        for (int i = 0; i < 4; i++) begin
            run_txn(vecs[i].q, vecs[i].bank, 0, 0);
            chk("t0", longint'(cap[vecs[i].bank][0]), 0);
            chk("t1", longint'(cap[vecs[i].bank][1]), longint'(vecs[i].t1));
            chk("t2", longint'(cap[vecs[i].bank][2]), longint'(vecs[i].t2));
            chk("t63", longint'(cap[vecs[i].bank][63]), longint'(vecs[i].t63));
            n_ge = 0;
            for (int k = 0; k < 64; k++) begin
                if (cap[vecs[i].bank][k] >= vecs[i].q) n_ge++;
            end
            chk("entries_below_q", longint'(n_ge), 0);
        end

        // start during WRITE with another q and bank 1 must not disturb the run
        run_txn(30'd1068564481, 1'b0, 30, 0);
        // reset while write k=20 is on the bus, then a fresh full run
        run_txn(30'd1068564481, 1'b0, 0, 22);
        run_txn(30'd1068564481, 1'b0, 0, 0);
        chk("rerun_t0", longint'(cap[0][0]), 0);
        chk("rerun_t63", longint'(cap[0][63]), 326172609);

`ifdef REDC_TABLE_RANGE_CHECK_EN
        run_err(30'd536870912);
        run_err(30'd268435457);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/reduction_table_writer.md
# reduction_table_writer

Runtime generator for the 64-entry window-reduction lookup tables used by the 60-bit windowed reduction datapath. On `start` it latches a 30-bit modulus and a bank select, then writes T[k] = (k · 2^30) mod q for k = 0..63 into an external table RAM, one entry per cycle. Reduction tables can then be RAM-based and reloaded when the modulus set changes, instead of being fixed ROMs per modular index.

## Interface
- No parameters. Table depth (64), index width (6) and entry width (30) are fixed.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request generation; sampled only in IDLE.
- `modulus` in 30: q, latched on an accepted `start`.
- `bank_sel` in 1: target bank (0 = S set, 1 = L set), latched on an accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last write.
- `err` out 1: one-cycle pulse on modulus rejection; only exists with `REDC_TABLE_RANGE_CHECK_EN`.
- `tbl_we` out 1: table write enable.
- `tbl_bank` out 1: latched bank select.
- `tbl_addr` out 6: entry index k.
- `tbl_data` out 30: T[k].

## Operation
- FSM states: IDLE, INIT, WRITE, DONE, plus ERR when the range check is compiled in.
- **IDLE**
  - If `start`=1: latch `modulus` into q_r and `bank_sel` into bank_r, then go to INIT.
  - Otherwise stay in IDLE.
- **INIT** (1 cycle)
  - r_r ← 2^30 − q_r (30-bit). This equals 2^30 mod q for 2^29 < q < 2^30.
  - k ← 0, acc ← 0, then go to WRITE.
  - With the check compiled in and q_r failing it, go to ERR instead.
- **WRITE** (64 cycles)
  - `tbl_we`=1, `tbl_addr`=k, `tbl_data`=acc.
  - sum = acc + r_r, computed 31 bits wide.
  - acc ← sum − q_r if sum ≥ q_r, else sum. acc stays < q_r.
  - k ← k+1. When k=63, go to DONE.
- **DONE** (1 cycle): `done`=1, then go to IDLE.
- **ERR** (1 cycle): `err`=1, no writes, then go to IDLE.
- `start` outside IDLE is ignored: no queueing and no restart.
- `modulus` and `bank_sel` changing after acceptance have no effect.
- All outputs are decoded from registered state (k, acc, bank_r, FSM). There is no combinational path from inputs to outputs.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `tbl_we`=0, `tbl_bank`=0, `tbl_addr`=0, `tbl_data`=0. FSM = IDLE; k, acc, q_r, r_r = 0.
- `start` is sampled at edge E0.
  - E0+1..E0+2: INIT.
  - Writes for k = 0..63 occupy the 64 cycles starting at E0+2.
  - `done` is high in the cycle starting at E0+66.
  - `busy` is high from E0+1 through the `done` cycle.
  - A new `start` is accepted at the first edge after `done` falls, i.e. E0+67 at the earliest.
- Error path: `err` is high in the cycle after INIT (E0+2). `tbl_we` never asserts.
- Reset mid-WRITE:
  - In the cycle after the reset edge, `tbl_we`=0, FSM = IDLE, and no `done` is issued.
  - Table contents are partially written and must be regenerated.
- `rst` together with `start`: reset wins.
- Throughput: one entry per cycle. The table RAM must accept a write every cycle while `tbl_we`=1.

## Configuration
- `REDC_TABLE_RANGE_CHECK_EN` defined:
  - INIT rejects q unless q[29]=1, q[0]=1, and q ≠ 2^29+... no upper limit beyond 30 bits (q < 2^30 is implicit in the width). In short, q must be odd and in (2^29, 2^30).
  - A rejected q goes to ERR and pulses `err`.
- Undefined:
  - No check; ERR state and `err` port are absent.
  - Out-of-range q produces unspecified table contents, but the FSM sequence and timing are unchanged.

## Test plan
- q=1068564481, bank_sel=0, start pulse -> 64 writes on bank 0 with T[0]=0, T[1]=5177343, T[2]=10354686, T[63]=326172609; `done` at E0+66.
- q=536870913 (wrap every step) -> T[1]=536870911, T[2]=536870909, T[63]=536870787; every entry < q.
- `start` asserted again during WRITE with a different q and bank_sel=1 -> ignored: remaining writes use the original q and bank 0, exactly 64 writes, one `done`.
- `rst` at write k=20 -> `tbl_we`=0 on the next cycle, no `done`; a fresh start then produces the full 64-entry sequence from T[0]=0.
- With `REDC_TABLE_RANGE_CHECK_EN`: q=536870912 (even) and q=268435457 (bit29=0) -> `err` pulse at E0+2, zero writes, `busy` low at E0+3.
- Cross-check: for each of the six S and six L production moduli, feed random 60-bit inputs to the reduction datapath using the generated tables -> result equals in mod q.
